// File: rtl/interrupt_sequencer_if.sv
// Bus and handshake bundle around the interrupt sequencer.
// The sequencer takes the master view: it drives the CPU bus while busy.
// The slave view belongs to the surroundings (control_unit, datapath, memory).
interface interrupt_sequencer_if;
  // interrupt sources and instruction-boundary qualifier
  logic        nmi_n;
  logic        irq_n;
  logic        brk_req;
  logic        i_flag;
  logic        instr_boundary;
  // processor context supplied by the datapath
  logic [15:0] pc_in;
  logic [7:0]  p_in;
  logic [7:0]  sp_in;
  // memory read data, valid in the same cycle as addr
  logic [7:0]  data_in;
  // bus and datapath controls owned by the sequencer
  logic        busy;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        read_write;
  logic        sp_dec;
  logic        pc_load;
  logic [15:0] pc_out;
  logic        set_i;

  modport master (
    input  nmi_n, irq_n, brk_req, i_flag, instr_boundary,
    input  pc_in, p_in, sp_in, data_in,
    output busy, addr, data_out, read_write, sp_dec, pc_load, pc_out, set_i
  );

  modport slave (
    output nmi_n, irq_n, brk_req, i_flag, instr_boundary,
    output pc_in, p_in, sp_in, data_in,
    input  busy, addr, data_out, read_write, sp_dec, pc_load, pc_out, set_i
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: takes the CPU bus for reset, NMI, IRQ and BRK entry.
// An entry pushes PCH, PCL and P to the stack page, fetches the 16-bit
// vector and hands it to the datapath with pc_load/set_i. Reset skips the
// pushes. Requests are only accepted at an instruction boundary.
module interrupt_sequencer #(
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_RST    = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic                   clk,
  input  logic                   rst,
  interrupt_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_PUSH_H,
    S_PUSH_L,
    S_PUSH_P,
    S_VEC_L,
    S_VEC_H,
    S_LOAD
  } state_t;

  typedef enum logic [1:0] {
    VS_RST,
    VS_NMI,
    VS_IRQ
  } vec_sel_t;

  state_t      state_q, state_d;
  vec_sel_t    vec_sel_q, vec_sel_d;
  logic        nmi_n_q;
  logic        nmi_pend_q, nmi_pend_d;
  logic        brk_q, brk_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;

  logic        nmi_edge;
  logic        nmi_now;
  logic        irq_req;
  logic        take_req;
  logic [15:0] vec_addr;

  // bits 5:4 of P are rebuilt on push, the live values are not needed
  logic        unused_p_bits;
  assign unused_p_bits = ^bus.p_in[5:4];

  // falling edge of the (already synchronised) NMI line
  assign nmi_edge = nmi_n_q & ~bus.nmi_n;
  // NMI either already latched or arriving this cycle
  assign nmi_now  = nmi_pend_q | nmi_edge;
  // IRQ is a live level, never latched, masked by the I flag
  assign irq_req  = ~bus.irq_n & ~bus.i_flag;
  assign take_req = bus.instr_boundary & (nmi_pend_q | bus.brk_req | irq_req);

  // vector low-byte address for the selected source
  always_comb begin
    case (vec_sel_q)
      VS_NMI:  vec_addr = VEC_NMI;
      VS_IRQ:  vec_addr = VEC_IRQ;
      default: vec_addr = VEC_RST;
    endcase
  end

  // state and sequence registers; reset can abort any sequence
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_RESET;
      vec_sel_q  <= VS_RST;
      nmi_pend_q <= 1'b0;
      brk_q      <= 1'b0;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
      // track the line through reset so no stale edge is seen on release
      nmi_n_q    <= bus.nmi_n;
    end else begin
      state_q    <= state_d;
      vec_sel_q  <= vec_sel_d;
      nmi_pend_q <= nmi_pend_d;
      brk_q      <= brk_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      nmi_n_q    <= bus.nmi_n;
    end
  end

  // next state, source selection, NMI latch and vector capture
  always_comb begin
    state_d    = state_q;
    vec_sel_d  = vec_sel_q;
    nmi_pend_d = nmi_pend_q | nmi_edge;
    brk_d      = brk_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    case (state_q)
      S_RESET: begin
        state_d = S_VEC_L;
      end
      S_IDLE: begin
        if (take_req) begin
          state_d = S_PUSH_H;
          // priority NMI > BRK > IRQ; BRK shares the IRQ vector
          vec_sel_d = nmi_pend_q ? VS_NMI : VS_IRQ;
          brk_d     = ~nmi_pend_q & bus.brk_req;
        end
      end
      S_PUSH_H: begin
        state_d = S_PUSH_L;
        // an NMI during the pushes hijacks the vector; B stays as pushed
        if (nmi_now) vec_sel_d = VS_NMI;
      end
      S_PUSH_L: begin
        state_d = S_PUSH_P;
        if (nmi_now) vec_sel_d = VS_NMI;
      end
      S_PUSH_P: begin
        state_d = S_VEC_L;
        if (nmi_now) vec_sel_d = VS_NMI;
        // NMI is consumed on entering VEC_L; a fresh edge this cycle survives
        if (nmi_now || vec_sel_q == VS_NMI) nmi_pend_d = nmi_edge;
      end
      S_VEC_L: begin
        state_d = S_VEC_H;
        lo_d    = bus.data_in;
      end
      S_VEC_H: begin
        state_d = S_LOAD;
        hi_d    = bus.data_in;
      end
      S_LOAD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // bus outputs decoded purely from the current state
  always_comb begin
    bus.busy       = 1'b1;
    bus.addr       = 16'h0000;
    bus.data_out   = 8'h00;
    bus.read_write = 1'b0;
    bus.sp_dec     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.set_i      = 1'b0;
    bus.pc_out     = 16'h0000;
    case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
      end
      S_PUSH_H: begin
        bus.addr       = {STACK_PAGE, bus.sp_in};
        bus.data_out   = bus.pc_in[15:8];
        bus.read_write = 1'b1;
        bus.sp_dec     = 1'b1;
      end
      S_PUSH_L: begin
        bus.addr       = {STACK_PAGE, bus.sp_in};
        bus.data_out   = bus.pc_in[7:0];
        bus.read_write = 1'b1;
        bus.sp_dec     = 1'b1;
      end
      S_PUSH_P: begin
        bus.addr       = {STACK_PAGE, bus.sp_in};
        bus.data_out   = {bus.p_in[7:6], 1'b1, brk_q, bus.p_in[3:0]};
        bus.read_write = 1'b1;
        bus.sp_dec     = 1'b1;
      end
      S_VEC_L: begin
        bus.addr = vec_addr;
      end
      S_VEC_H: begin
        bus.addr = vec_addr + 16'd1;
      end
      S_LOAD: begin
        bus.pc_out  = {hi_q, lo_q};
        bus.pc_load = 1'b1;
        bus.set_i   = 1'b1;
      end
      default: begin
        // RESET: own the bus but keep it quiet
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios plus a
// randomized run compared with a transaction-level model of an entry.
module tb_interrupt_sequencer;

  logic clk = 1'b0;
  logic rst;
  interrupt_sequencer_if bus();

  interrupt_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // memory image and stack pointer emulation
  logic [7:0]  mem [0:65535];
  logic [7:0]  sp_base      = 8'h00;
  logic [7:0]  sp_dec_total = 8'h00;
  int          cyc          = 0;
  int          busy_cnt     = 0;
  int          tests        = 0;
  int          fails        = 0;

  // observed bus activity
  logic [15:0] wq_addr [$];
  logic [7:0]  wq_data [$];
  logic [15:0] rq_addr [$];
  logic [15:0] lq_pc   [$];
  int          lq_cyc  [$];
  logic        lq_seti [$];

  // expected entry trace
  logic [15:0] exp_waddr [3];
  logic [7:0]  exp_wdata [3];
  logic [15:0] exp_vec;
  logic [15:0] exp_pc;

  assign bus.data_in = mem[bus.addr];
  assign bus.sp_in   = sp_base - sp_dec_total;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.sp_dec) sp_dec_total <= sp_dec_total + 8'd1;
  end

  always @(negedge clk) begin
    if (bus.busy) busy_cnt <= busy_cnt + 1;
    if (bus.busy && bus.read_write) begin
      wq_addr.push_back(bus.addr);
      wq_data.push_back(bus.data_out);
    end
    if (bus.busy && !bus.read_write && bus.addr != 16'h0000) rq_addr.push_back(bus.addr);
    if (bus.pc_load) begin
      lq_pc.push_back(bus.pc_out);
      lq_cyc.push_back(cyc);
      lq_seti.push_back(bus.set_i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: an entry writes PCH, PCL, P downward from SP, then reads the vector
  task automatic model_entry(input bit brk, input bit to_nmi, input logic [15:0] pc,
                             input logic [7:0] sp, input logic [7:0] p);
    exp_vec = to_nmi ? 16'hFFFA : 16'hFFFE;
    for (int k = 0; k < 3; k++) exp_waddr[k] = {8'h01, sp - 8'(k)};
    exp_wdata[0] = pc[15:8];
    exp_wdata[1] = pc[7:0];
    exp_wdata[2] = {p[7:6], 1'b1, brk, p[3:0]};
    exp_pc = {mem[exp_vec + 16'd1], mem[exp_vec]};
  endtask

  // present context and one boundary cycle; returns in the PUSH_H cycle
  task automatic start_entry(input logic [15:0] pc, input logic [7:0] sp,
                             input logic [7:0] p, output int bc);
    bus.pc_in = pc;
    bus.p_in  = p;
    sp_base   = sp + sp_dec_total;
    bus.instr_boundary = 1'b1;
    bc = cyc;
    step();
    bus.instr_boundary = 1'b0;
    bus.brk_req = 1'b0;
  endtask

  task automatic test_reset();
    int rc;
    mem[16'hFFFC] = 8'h34;
    mem[16'hFFFD] = 8'h12;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b1 || bus.addr !== 16'h0 || bus.read_write !== 1'b0 ||
          bus.data_out !== 8'h0 || bus.pc_out !== 16'h0) begin
        fails++;
        $display("FAIL reset_bus: got busy=%b addr=%h rw=%b do=%h pc_out=%h exp 1/0000/0/00/0000",
                 bus.busy, bus.addr, bus.read_write, bus.data_out, bus.pc_out);
      end
      tests++;
      if ({bus.sp_dec, bus.pc_load, bus.set_i} !== 3'b000) begin
        fails++;
        $display("FAIL reset_pulses: got %b exp 000", {bus.sp_dec, bus.pc_load, bus.set_i});
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    rc = cyc;
    repeat (6) step();
    tests++;
    if (rq_addr.size() != 2 || rq_addr[0] !== 16'hFFFC || rq_addr[1] !== 16'hFFFD) begin
      fails++;
      $display("FAIL reset_reads: got %0d reads first=%h exp FFFC,FFFD", rq_addr.size(),
               (rq_addr.size() > 0) ? rq_addr[0] : 16'h0);
    end
    tests++;
    if (wq_addr.size() != 0) begin
      fails++;
      $display("FAIL reset_no_push: got %0d writes exp 0", wq_addr.size());
    end
    tests++;
    if (lq_pc.size() != 1 || lq_pc[0] !== 16'h1234 || lq_seti[0] !== 1'b1 || lq_cyc[0] - rc != 3) begin
      fails++;
      $display("FAIL reset_load: got n=%0d pc=%h set_i=%b lat=%0d exp 1/1234/1/3", lq_pc.size(),
               (lq_pc.size() > 0) ? lq_pc[0] : 16'h0, (lq_seti.size() > 0) ? lq_seti[0] : 1'b0,
               (lq_cyc.size() > 0) ? lq_cyc[0] - rc : -1);
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b exp 0", bus.busy);
    end
    $display("[TB] reset entry -> pc_out=%h", (lq_pc.size() > 0) ? lq_pc[0] : 16'h0);
  endtask

  task automatic test_irq();
    int wb, rb, lb, bc;
    mem[16'hFFFE] = 8'($urandom);
    mem[16'hFFFF] = 8'($urandom);
    wb = wq_addr.size(); rb = rq_addr.size(); lb = lq_pc.size();
    bus.i_flag = 1'b0;
    bus.irq_n  = 1'b0;
    start_entry(16'hC005, 8'hFD, 8'h20, bc);
    repeat (8) step();
    bus.irq_n  = 1'b1;
    bus.i_flag = 1'b1;
    model_entry(1'b0, 1'b0, 16'hC005, 8'hFD, 8'h20);
    tests++;
    if (wq_addr.size() - wb != 3) begin
      fails++;
      $display("FAIL irq_wcount: got %0d exp 3", wq_addr.size() - wb);
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (wq_addr[wb+k] !== exp_waddr[k] || wq_data[wb+k] !== exp_wdata[k]) begin
          fails++;
          $display("FAIL irq_write%0d: got %h=%h exp %h=%h", k, wq_addr[wb+k], wq_data[wb+k],
                   exp_waddr[k], exp_wdata[k]);
        end
      end
    end
    tests++;
    if (rq_addr.size() - rb != 2 || rq_addr[rb] !== 16'hFFFE || rq_addr[rb+1] !== 16'hFFFF) begin
      fails++;
      $display("FAIL irq_vec_reads: got %0d reads first=%h exp FFFE,FFFF", rq_addr.size() - rb,
               (rq_addr.size() > rb) ? rq_addr[rb] : 16'h0);
    end
    tests++;
    if (lq_pc.size() - lb != 1 || lq_pc[lb] !== exp_pc || lq_cyc[lb] - bc != 6) begin
      fails++;
      $display("FAIL irq_load: got n=%0d pc=%h lat=%0d exp 1/%h/6", lq_pc.size() - lb,
               (lq_pc.size() > lb) ? lq_pc[lb] : 16'h0, (lq_cyc.size() > lb) ? lq_cyc[lb] - bc : -1, exp_pc);
    end
    $display("[TB] irq entry pc=C005 sp=FD p=20 -> pc_out=%h", exp_pc);
  endtask

  task automatic test_mask_brk();
    int b0, wb, rb, lb, bc;
    logic [7:0] got;
    bus.i_flag = 1'b1;
    bus.irq_n  = 1'b0;
    b0 = busy_cnt;
    for (int n = 0; n < 20; n++) begin
      bus.instr_boundary = 1'b1;
      step();
      bus.instr_boundary = 1'b0;
      step();
    end
    tests++;
    if (busy_cnt != b0) begin
      fails++;
      $display("FAIL mask_busy: got %0d busy cycles exp 0", busy_cnt - b0);
    end
    wb = wq_addr.size(); rb = rq_addr.size(); lb = lq_pc.size();
    bus.brk_req = 1'b1;
    start_entry(16'h9ABC, 8'hF0, 8'h20, bc);
    repeat (8) step();
    bus.irq_n = 1'b1;
    got = (wq_data.size() > wb + 2) ? wq_data[wb+2] : 8'h00;
    tests++;
    if (wq_data.size() - wb != 3 || got !== 8'h30) begin
      fails++;
      $display("FAIL brk_p_push: got n=%0d p=%h exp 3/30", wq_data.size() - wb, got);
    end
    tests++;
    if (rq_addr.size() - rb != 2 || rq_addr[rb] !== 16'hFFFE) begin
      fails++;
      $display("FAIL brk_vector: got %h exp FFFE", (rq_addr.size() > rb) ? rq_addr[rb] : 16'h0);
    end
    $display("[TB] masked irq x20 then brk -> p pushed %h", got);
  endtask

  task automatic test_nmi_hijack();
    int b0, wb, rb, lb, bc;
    logic [7:0] got;
    mem[16'hFFFA] = 8'($urandom);
    mem[16'hFFFB] = 8'($urandom);
    wb = wq_addr.size(); rb = rq_addr.size(); lb = lq_pc.size();
    bus.i_flag = 1'b0;
    bus.irq_n  = 1'b0;
    start_entry(16'h5A5A, 8'h80, 8'h20, bc);
    step();
    bus.nmi_n = 1'b0;
    repeat (7) step();
    bus.irq_n  = 1'b1;
    bus.i_flag = 1'b1;
    got = (wq_data.size() > wb + 2) ? wq_data[wb+2] : 8'h00;
    tests++;
    if (rq_addr.size() - rb != 2 || rq_addr[rb] !== 16'hFFFA) begin
      fails++;
      $display("FAIL hijack_vector: got %h exp FFFA", (rq_addr.size() > rb) ? rq_addr[rb] : 16'h0);
    end
    tests++;
    if (got !== 8'h20) begin
      fails++;
      $display("FAIL hijack_b_bit: got p=%h exp 20", got);
    end
    tests++;
    if (lq_pc.size() - lb != 1 || lq_pc[lb] !== {mem[16'hFFFB], mem[16'hFFFA]}) begin
      fails++;
      $display("FAIL hijack_load: got %h exp %h", (lq_pc.size() > lb) ? lq_pc[lb] : 16'h0,
               {mem[16'hFFFB], mem[16'hFFFA]});
    end
    b0 = busy_cnt;
    repeat (4) begin
      bus.instr_boundary = 1'b1;
      step();
      bus.instr_boundary = 1'b0;
      step();
    end
    tests++;
    if (busy_cnt != b0) begin
      fails++;
      $display("FAIL hijack_pend_clear: got %0d busy cycles exp 0", busy_cnt - b0);
    end
    bus.nmi_n = 1'b1;
    step();
    $display("[TB] irq hijacked by nmi -> pc_out=%h", {mem[16'hFFFB], mem[16'hFFFA]});
  endtask

  task automatic test_simul();
    int b0, wb, rb, bc;
    bus.irq_n  = 1'b0;
    bus.i_flag = 1'b0;
    bus.nmi_n  = 1'b0;
    step();
    wb = wq_addr.size(); rb = rq_addr.size();
    start_entry(16'h1357, 8'h40, 8'hC3, bc);
    repeat (8) step();
    bus.i_flag = 1'b1;
    tests++;
    if (rq_addr.size() - rb != 2 || rq_addr[rb] !== 16'hFFFA) begin
      fails++;
      $display("FAIL simul_vector: got %h exp FFFA", (rq_addr.size() > rb) ? rq_addr[rb] : 16'h0);
    end
    tests++;
    if (wq_data.size() - wb != 3 || wq_data[wb+2] !== 8'hE3) begin
      fails++;
      $display("FAIL simul_p_push: got %h exp E3", (wq_data.size() > wb + 2) ? wq_data[wb+2] : 8'h0);
    end
    b0 = busy_cnt;
    repeat (5) begin
      bus.instr_boundary = 1'b1;
      step();
      bus.instr_boundary = 1'b0;
      step();
    end
    tests++;
    if (busy_cnt != b0) begin
      fails++;
      $display("FAIL simul_irq_masked: got %0d busy cycles exp 0", busy_cnt - b0);
    end
    bus.irq_n = 1'b1;
    bus.nmi_n = 1'b1;
    step();
    $display("[TB] nmi+irq at boundary -> vector FFFA taken");
  endtask

  task automatic test_reset_mid();
    int wb, rb, lb, bc, rc;
    logic [15:0] rv;
    mem[16'hFFFC] = 8'($urandom);
    mem[16'hFFFD] = 8'($urandom);
    rv = {mem[16'hFFFD], mem[16'hFFFC]};
    wb = wq_addr.size(); rb = rq_addr.size(); lb = lq_pc.size();
    bus.irq_n  = 1'b0;
    bus.i_flag = 1'b0;
    start_entry(16'h4321, 8'hFF, 8'h00, bc);
    step();
    step();
    rst = 1'b0;
    bus.irq_n = 1'b1;
    step();
    tests++;
    if (bus.busy !== 1'b1 || bus.read_write !== 1'b0 || bus.addr !== 16'h0) begin
      fails++;
      $display("FAIL midrst_state: got busy=%b rw=%b addr=%h exp 1/0/0000", bus.busy, bus.read_write, bus.addr);
    end
    step();
    rst = 1'b1;
    bus.i_flag = 1'b1;
    rc = cyc;
    repeat (6) step();
    tests++;
    if (wq_addr.size() - wb != 3) begin
      fails++;
      $display("FAIL midrst_writes: got %0d exp 3", wq_addr.size() - wb);
    end
    tests++;
    if (rq_addr.size() - rb != 2 || rq_addr[rb] !== 16'hFFFC || rq_addr[rb+1] !== 16'hFFFD) begin
      fails++;
      $display("FAIL midrst_reads: got %0d reads first=%h exp FFFC,FFFD", rq_addr.size() - rb,
               (rq_addr.size() > rb) ? rq_addr[rb] : 16'h0);
    end
    tests++;
    if (lq_pc.size() - lb != 1 || lq_pc[lb] !== rv || lq_cyc[lb] - rc != 3) begin
      fails++;
      $display("FAIL midrst_load: got n=%0d pc=%h exp 1/%h", lq_pc.size() - lb,
               (lq_pc.size() > lb) ? lq_pc[lb] : 16'h0, rv);
    end
    $display("[TB] reset during PUSH_P -> restart pc_out=%h", rv);
  endtask

  task automatic test_random();
    int kind, hij_at, wb, rb, lb, bc;
    bit hij;
    logic [15:0] pc;
    logic [7:0] sp, p;
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 2);
      hij = (kind != 2) && ($urandom_range(0, 2) == 0);
      hij_at = $urandom_range(1, 2);
      pc = 16'($urandom);
      p  = 8'($urandom);
      sp = (it == 0) ? 8'h01 : 8'($urandom);
      for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
      bus.irq_n  = 1'($urandom_range(0, 1));
      bus.i_flag = 1'($urandom_range(0, 1));
      case (kind)
        0: begin bus.irq_n = 1'b0; bus.i_flag = 1'b0; end
        1: bus.brk_req = 1'b1;
        default: begin bus.brk_req = 1'($urandom_range(0, 1)); bus.nmi_n = 1'b0; step(); end
      endcase
      wb = wq_addr.size(); rb = rq_addr.size(); lb = lq_pc.size();
      start_entry(pc, sp, p, bc);
      for (int s = 1; s <= 8; s++) begin
        if (hij && s == hij_at) bus.nmi_n = 1'b0;
        step();
      end
      model_entry(kind == 1, (kind == 2) || hij, pc, sp, p);
      tests++;
      if (wq_addr.size() - wb != 3) begin
        fails++;
        $display("FAIL rnd%0d_wcount: got %0d exp 3", it, wq_addr.size() - wb);
      end else begin
        for (int k = 0; k < 3; k++) begin
          tests++;
          if (wq_addr[wb+k] !== exp_waddr[k] || wq_data[wb+k] !== exp_wdata[k]) begin
            fails++;
            $display("FAIL rnd%0d_write%0d: got %h=%h exp %h=%h", it, k, wq_addr[wb+k], wq_data[wb+k],
                     exp_waddr[k], exp_wdata[k]);
          end
        end
      end
      tests++;
      if (rq_addr.size() - rb != 2 || rq_addr[rb] !== exp_vec || rq_addr[rb+1] !== exp_vec + 16'd1) begin
        fails++;
        $display("FAIL rnd%0d_reads: got %0d reads first=%h exp %h", it, rq_addr.size() - rb,
                 (rq_addr.size() > rb) ? rq_addr[rb] : 16'h0, exp_vec);
      end
      tests++;
      if (lq_pc.size() - lb != 1 || lq_pc[lb] !== exp_pc || lq_seti[lb] !== 1'b1 || lq_cyc[lb] - bc != 6) begin
        fails++;
        $display("FAIL rnd%0d_load: got n=%0d pc=%h lat=%0d exp 1/%h/6", it, lq_pc.size() - lb,
                 (lq_pc.size() > lb) ? lq_pc[lb] : 16'h0, (lq_cyc.size() > lb) ? lq_cyc[lb] - bc : -1, exp_pc);
      end
      $display("[TB] rnd %0d kind=%0d hijack=%0d pc=%h sp=%h p=%h -> vec=%h pc_out=%h",
               it, kind, hij, pc, sp, p, exp_vec, exp_pc);
      bus.irq_n   = 1'b1;
      bus.nmi_n   = 1'b1;
      bus.brk_req = 1'b0;
      bus.i_flag  = 1'b1;
      step();
      step();
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.nmi_n = 1'b1;
    bus.irq_n = 1'b1;
    bus.brk_req = 1'b0;
    bus.i_flag = 1'b1;
    bus.instr_boundary = 1'b0;
    bus.pc_in = 16'h0000;
    bus.p_in = 8'h00;
    test_reset();
    test_irq();
    test_mask_brk();
    test_nmi_hijack();
    test_simul();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
